// File: rtl/table_rmw_updater.sv
// Purpose: read-modify-write front end for a DEPTH x DW saturating-counter table; sweeps INIT_VAL after reset.
// Latency: lookup response 1 cycle after accept; update written 2 cycles after accept.
// Backpressure: lk_ready/upd_ready low during the sweep, and (without TABLE_RMW_BYPASS_EN) one cycle on an S1 update index hit.
module table_rmw_updater #(
    parameter int              DEPTH    = 1024,
    parameter int              AW       = 10,
    parameter int              DW       = 7,
    parameter logic [DW-1:0]   INIT_VAL = 7'h40
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          lk_valid,
    output logic          lk_ready,
    input  logic [AW-1:0] lk_idx,
    output logic          lk_resp_valid,
    output logic [DW-1:0] lk_resp_data,
    input  logic          upd_valid,
    output logic          upd_ready,
    input  logic [AW-1:0] upd_idx,
    input  logic          upd_inc,
    output logic          init_done,
    output logic          sram_r_en,
    output logic [AW-1:0] sram_r_addr,
    input  logic [DW-1:0] sram_r_data,
    output logic          sram_w_en,
    output logic [AW-1:0] sram_w_addr,
    output logic [DW-1:0] sram_w_data
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;

    // S1 (data) and S2 (write) pipeline registers
    logic          s1_vld;
    logic          s1_upd;
    logic          s1_inc;
    logic [AW-1:0] s1_idx;
    logic          s2_vld;
    logic [AW-1:0] s2_idx;
    logic [DW-1:0] s2_wdat;

    logic          run;
    logic          stall;
    logic          lk_fire;
    logic          upd_fire;
    logic [AW-1:0] req_idx;
    logic [DW-1:0] cur;
    logic [DW-1:0] nxt;

    assign run = (state == ST_RUN);

    // Sweep FSM: write INIT_VAL to every entry once, then stay in RUN until reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == AW'(DEPTH - 1)) begin
                        state     <= ST_RUN;
                        cnt       <= '0;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    init_done <= 1'b1;
                end
            endcase
        end
    end

    // The S0 request index: a pending lookup wins over a pending update
    assign req_idx = lk_valid ? lk_idx : upd_idx;

`ifdef TABLE_RMW_BYPASS_EN
    assign stall = 1'b0;
`else
    // Hold the request one cycle so its read coincides with the S2 write of the same entry
    assign stall = s1_vld && s1_upd && (req_idx == s1_idx);
`endif

    assign lk_ready  = run && !stall;
    assign upd_ready = run && !lk_valid && !stall;
    assign lk_fire   = lk_valid && lk_ready;
    assign upd_fire  = upd_valid && upd_ready;

    // S0 issue: one table read per accepted request; address idles at zero
    always_comb begin
        sram_r_en   = 1'b0;
        sram_r_addr = '0;
        if (lk_fire || upd_fire) begin
            sram_r_en   = 1'b1;
            sram_r_addr = req_idx;
        end
    end

    // S0 -> S1 capture of the accepted request
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1_upd <= 1'b0;
            s1_inc <= 1'b0;
            s1_idx <= '0;
        end else begin
            s1_vld <= lk_fire || upd_fire;
            s1_upd <= upd_fire;
            s1_inc <= upd_inc;
            s1_idx <= req_idx;
        end
    end

`ifdef TABLE_RMW_BYPASS_EN
    // The S2 write has not reached the table yet when S1 reads, so forward it
    assign cur = (s2_vld && (s2_idx == s1_idx)) ? s2_wdat : sram_r_data;
`else
    assign cur = sram_r_data;
`endif

    // S1 saturating modify and lookup response
    always_comb begin
        nxt = cur;
        if (s1_inc) begin
            if (cur != {DW{1'b1}}) begin
                nxt = cur + DW'(1);
            end
        end else begin
            if (cur != '0) begin
                nxt = cur - DW'(1);
            end
        end
        lk_resp_valid = s1_vld && !s1_upd;
        lk_resp_data  = lk_resp_valid ? cur : '0;
    end

    // S1 -> S2 capture; only updates proceed to the write stage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_vld  <= 1'b0;
            s2_idx  <= '0;
            s2_wdat <= '0;
        end else begin
            s2_vld  <= s1_vld && s1_upd;
            s2_idx  <= s1_idx;
            s2_wdat <= nxt;
        end
    end

    // Table write port: sweep writes during INIT, S2 writes in RUN; reset silences the port at once
    always_comb begin
        sram_w_en   = 1'b0;
        sram_w_addr = '0;
        sram_w_data = '0;
        if (!reset) begin
            if (state == ST_INIT) begin
                sram_w_en   = 1'b1;
                sram_w_addr = cnt;
                sram_w_data = INIT_VAL;
            end else if (s2_vld) begin
                sram_w_en   = 1'b1;
                sram_w_addr = s2_idx;
                sram_w_data = s2_wdat;
            end
        end
    end

endmodule

// File: doc/table_rmw_updater.md
# table_rmw_updater

Read-modify-write front end for one 1024×7 saturating-counter predictor table macro. It sits directly upstream of the table SRAM and owns both of its ports. It clears the table to a fixed value after reset, serves single-cycle-latency lookups, and applies +1/−1 saturating updates through a 3-stage pipeline. Read-after-write hazards are resolved by forwarding or by stalling.

## Interface
Parameters:
- `DEPTH`, 1024: table entries.
- `AW`, 10: index width; `DEPTH == 2**AW`.
- `DW`, 7: entry width.
- `INIT_VAL`, 7'h40: value written to every entry by the reset sweep.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `lk_valid`  in  1  lookup request.
- `lk_ready`  out  1  lookup accepted when `lk_valid && lk_ready`.
- `lk_idx`  in  AW  lookup index.
- `lk_resp_valid`  out  1  lookup response strobe.
- `lk_resp_data`  out  DW  lookup response value.
- `upd_valid`  in  1  update request.
- `upd_ready`  out  1  update accepted when `upd_valid && upd_ready`.
- `upd_idx`  in  AW  update index.
- `upd_inc`  in  1  1 = increment, 0 = decrement.
- `init_done`  out  1  high once the sweep completes.
- `sram_r_en`  out  1  to table read enable.
- `sram_r_addr`  out  AW  to table read address.
- `sram_r_data`  in  DW  from table; valid the cycle after `sram_r_en`.
- `sram_w_en`  out  1  to table write enable.
- `sram_w_addr`  out  AW  to table write address.
- `sram_w_data`  out  DW  to table write data.

## Operation
- Top-level FSM has two states.
  - INIT: entered on reset. Drives `sram_w_en=1`, `sram_w_addr=cnt`, `sram_w_data=INIT_VAL`; `cnt` increments each cycle. When the cycle with `cnt==DEPTH-1` completes, the FSM moves to RUN. `lk_ready`, `upd_ready` and `sram_r_en` stay 0 throughout INIT.
  - RUN: `init_done=1`; the FSM remains in RUN until reset.
- S0, issue (RUN only): at most one read per cycle.
  - A lookup has priority over an update.
  - `lk_ready = RUN && !stall`.
  - `upd_ready = RUN && !lk_valid && !stall`.
  - On either handshake, drive `sram_r_en=1` and `sram_r_addr=idx`, and register {valid, is_upd, idx, inc} into S1.
- S1, data: `cur = (S2.valid && S2.idx==S1.idx) ? S2.wdata : sram_r_data` (forwarding).
  - Lookup: `lk_resp_valid=1`, `lk_resp_data=cur`.
  - Update: `nxt = inc ? (cur==7'h7F ? 7'h7F : cur+1) : (cur==0 ? 0 : cur−1)`. Arithmetic is DW bits with no wrap. S1 registers {idx, nxt} into S2.
- S2, write: `sram_w_en=1`, `sram_w_addr=S2.idx`, `sram_w_data=S2.wdata`.
  - Lookups never enter S2.
  - The table returns the new value for a read issued in the same cycle as a write to the same index. Therefore only the S1/S2 match needs forwarding.
- `stall` is 0 when bypass is compiled in; see Configuration.
- Reset at any time, including mid-sweep or mid-pipeline:
  - All pipeline valids clear and in-flight writes are dropped.
  - `cnt` returns to 0 and the FSM returns to INIT, so the sweep restarts from entry 0.

## Timing
- Reset values of outputs: `lk_ready`, `upd_ready`, `lk_resp_valid`, `init_done`, `sram_r_en` and `sram_w_en` are 0. All addresses and data outputs are 0.
- Sweep length: reset deasserts before edge 0. Writes occur in cycles 0..1023, and `init_done` rises in cycle 1024.
- Lookup latency: accepted in cycle t; response in cycle t+1.
- Update latency: accepted in cycle t; write driven in cycle t+2 and visible to a read issued in cycle t+2 or later.
- With bypass, one lookup or one update can be accepted every RUN cycle.
- An index collision in back-to-back cycles causes no bubble.

## Configuration
- Macro `TABLE_RMW_BYPASS_EN`.
- Defined: S1 forwarding is active; `stall = 0`.
- Undefined: there is no forwarding mux, and `cur = sram_r_data`.
  - `stall = S1.valid && S1.is_upd && (S0 request idx == S1.idx)`, where the S0 request is the lookup if `lk_valid`, else the update.
  - This forces a one-cycle bubble so the read lands in the same cycle as the S2 write.
  - Results are identical to the defined build; only throughput differs.

## Test plan
- Reset, then wait → 1024 writes of 0x40 to addresses 0..1023 in order; `init_done` rises in cycle 1024; a lookup of idx 5 returns 0x40 one cycle later.
- Three back-to-back `upd_inc=1` on idx 3 (bypass build) → accepted in 3 consecutive cycles with no stall; stored value 0x43; a following lookup of idx 3 returns 0x43.
- 70 increments on idx 0 → 0x7F (saturated, no wrap to 0); then 200 decrements → 0x00; the table never goes below 0.
- `lk_valid` and `upd_valid` high in the same cycle (idx 9 and idx 10) → lookup accepted and `upd_ready=0`; update accepted the next cycle; `lk_resp_data=0x40`; idx 10 becomes 0x41.
- Assert `reset` while `cnt==500` → all outputs go to 0 immediately; after deassert, the sweep restarts at address 0 and `init_done` rises 1024 cycles later.
- Build without `TABLE_RMW_BYPASS_EN`: update idx 7 (inc) followed immediately by lookup idx 7 → `lk_ready=0` for exactly one cycle; the lookup then returns 0x41.
